axis_i2c_cmd: RTL

AXIS_I2C_CMD -- requirements
Module: axis_i2c_cmd

---
 rtl/axis_i2c_cmd_if.sv | 28 ++
 rtl/axis_i2c_cmd.sv | 118 +++++++++++
 2 files changed

// File: rtl/axis_i2c_cmd_if.sv
// Command stream in, I2C engine handshake out, and FIFO occupancy for axis_i2c_cmd.
// slave is the controller's view; master is the view of whatever drives commands and models the engine.
interface axis_i2c_cmd_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 4
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [ADDR_WIDTH+DATA_WIDTH-1:0] s_axis_tdata;
  logic                             s_axis_tvalid;
  logic                             s_axis_tready;
  logic                             fsm_ready;
  logic                             fsm_start;
  logic [ADDR_WIDTH-1:0]            fsm_addr;
  logic [DATA_WIDTH-1:0]            fsm_data;
  logic [LVL_W-1:0]                 fifo_level;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, fsm_ready,
    output s_axis_tready, fsm_start, fsm_addr, fsm_data, fifo_level
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, fsm_ready,
    input  s_axis_tready, fsm_start, fsm_addr, fsm_data, fifo_level
  );
endinterface

// File: rtl/axis_i2c_cmd.sv
// Queues AXI-Stream {addr,data} commands and issues them one at a time to an I2C engine.
// Define AXIS_I2C_CMD_DONE_EN to add the cmd_done completion pulse output.
//   state     | meaning
//   IDLE      | waiting for a queued command and an idle engine
//   ISSUE     | fsm_start high for this single cycle
//   WAIT_ACK  | waiting for the engine to drop fsm_ready
//   WAIT_DONE | engine busy; waiting for fsm_ready to return
module axis_i2c_cmd #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 4
) (
  input  logic             clk,
  input  logic             arst,
  axis_i2c_cmd_if.slave    bus
`ifdef AXIS_I2C_CMD_DONE_EN
  ,
  output logic             cmd_done
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         mem_q [DEPTH];
  logic                  full, empty, push, pop;
  logic                  start_q, start_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
`ifdef AXIS_I2C_CMD_DONE_EN
  logic                  done_q, done_d;
`endif

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = bus.s_axis_tvalid && bus.s_axis_tready;

  assign bus.s_axis_tready = !full && !arst;
  assign bus.fifo_level    = wr_ptr_q - rd_ptr_q;
  assign bus.fsm_start     = start_q;
  assign bus.fsm_addr      = addr_q;
  assign bus.fsm_data      = data_q;
`ifdef AXIS_I2C_CMD_DONE_EN
  assign cmd_done          = done_q;
`endif

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage is never read before it is written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.s_axis_tdata;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    start_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef AXIS_I2C_CMD_DONE_EN
    done_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!empty && bus.fsm_ready) begin
          pop              = 1'b1;
          {addr_d, data_d} = mem_q[rd_ptr_q[AW-1:0]];
          start_d          = 1'b1;
          state_d          = ISSUE;
        end
      end
      ISSUE:    state_d = WAIT_ACK;
      WAIT_ACK: if (!bus.fsm_ready) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (bus.fsm_ready) begin
          state_d = IDLE;
`ifdef AXIS_I2C_CMD_DONE_EN
          done_d  = 1'b1;
`endif
        end
      end
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef AXIS_I2C_CMD_DONE_EN
      done_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef AXIS_I2C_CMD_DONE_EN
      done_q  <= done_d;
`endif
    end
  end
endmodule
